cpu_mem_responder: RTL and testbench
====================================

# cpu_mem_responder

Memory-side responder for the pipelined MIPS core's two memory ports: it answers instruction fetches (`pcF` to `instrF`) and memory-stage data accesses (`aluoutM`, `memwriteM`, `writedataM` to `readdataM`) from one on-chip word array. Stores go through a one-entry store buffer with byte-lane forwarding. A small MMIO window holds a cycle counter, an output register and a sticky address-error status. It sits directly under the SoC top, beside the core, as the other end of the core's memory interface.

## Interface
- `DEPTH_LOG2`, default 10: array holds 2^DEPTH_LOG2 32-bit words.
- `MMIO_BASE`, default 32'h1FAF_0000: physical base of the 16-byte MMIO window.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-low.
- `pcF`  in  32  instruction fetch address (virtual).
- `instrF`  out  32  fetched instruction, combinational.
- `aluoutM`  in  32  data address (virtual).
- `memwriteM`  in  4  byte-lane write enables; 0 means no store.
- `writedataM`  in  32  store data, already lane-aligned by the core.
- `readdataM`  out  32  load data (full word), combinational.
- `mmio_out`  out  32  MMIO output register.
- `addr_err`  out  1  sticky error flag.
- `err_addr`  out  32  first offending address since the last clear.

## Operation
- **Physical address:** `pa = va & 32'h1FFF_FFFF`.
- **Address decode:**
  - RAM hit when `pa[31:DEPTH_LOG2+2] == 0`.
  - Word index is `pa[DEPTH_LOG2+1:2]`.
  - MMIO hit when `pa[31:4] == MMIO_BASE[31:4]`.
  - Anything else is unmapped.
- **Reads:** combinational, zero-latency, on both ports.
  - RAM: array word, then per-lane forwarding. If the buffer is valid and the buffer index equals the read index, each lane whose buffered enable is set takes the buffered byte.
  - Unmapped data read returns 0.
  - Unmapped fetch returns 0 (NOP).
- **Store buffer:** fields `sb_valid`, `sb_idx`, `sb_be[3:0]`, `sb_data`.
  - Each edge: if `sb_valid`, merge the enabled lanes into `array[sb_idx]`.
  - Same edge: if a RAM store is present (`memwriteM != 0`, RAM hit), load the buffer with it; otherwise clear `sb_valid`.
  - A back-to-back store to the same index commits the old entry and captures the new one on that edge. No stall is ever needed.
- **MMIO map** (offset = `pa[3:2]`):
  - 0: cycle counter, read-only. Stores are ignored, no error.
  - 1: `mmio_out`, read/write with byte enables.
  - 2: status, reads `{31'b0, addr_err}`. Any store with nonzero enables clears `addr_err` and `err_addr`.
  - 3: reads 0, stores ignored.
- **Error events:**
  - Store to an unmapped address: data is dropped.
  - Fetch with `pcF[1:0] != 0`, or fetch from an unmapped address.
  - On an event, set `addr_err`. Capture `err_addr` (the virtual address; the data address takes priority over `pcF`) only if `addr_err` was 0.
- **Cycle counter:** increments by 1 every non-reset cycle; wraps from 32'hFFFF_FFFF to 0.

## Timing
- Read latency is 0 cycles on both ports.
- A store issued in cycle N is visible to loads and fetches in cycle N+1 via forwarding, and is in the array after edge N+1.
- `mmio_out` updates on the edge that ends the store cycle.
- Reset values:
  - `sb_valid` 0; a pending store at reset is discarded.
  - Counter 0; it reads 0 in the first cycle after reset.
  - `mmio_out` 0, `addr_err` 0, `err_addr` 0.
  - The array is not reset.
- **Simultaneous events:**
  - A status-clear store in the same cycle as a new error event: set wins, and `err_addr` takes the new address.
  - A fetch and a store to the same word in the same cycle: the fetch returns the pre-store value.

## Configuration
- Macro `CPU_MEM_MMIO_EN`.
- Defined: MMIO window, counter, `mmio_out` and status register are present as above.
- Undefined:
  - The MMIO window decodes as unmapped, so stores there raise `addr_err`.
  - `mmio_out` is tied to 0.
  - No counter logic is synthesized.
  - `addr_err` can then only be cleared by reset.

## Structure
- A shared package holds:
  - MMIO offset constants: `MMIO_CYCLE=0`, `MMIO_OUT=1`, `MMIO_STATUS=2`.
  - The physical mask 32'h1FFF_FFFF.
  - The region enum `{REG_RAM, REG_MMIO, REG_UNMAPPED}`.
  - The store-buffer entry struct.
- One sub-module, `mem_addr_decode`: combinational classifier instantiated twice (fetch port and data port), producing region, index and MMIO offset.

## Test plan
- **Store then load forward:** store `be=4'b1111`, data 32'hDEAD_BEEF at 0x8000_0010; load the same address next cycle. `readdataM` = 32'hDEAD_BEEF (forwarded), and it still matches two cycles later (from the array).
- **Byte-lane merge:** word holds 32'h1122_3344; store `be=4'b0010`, data 32'h0000_AA00. The next load returns 32'h1122_AA44.
- **Back-to-back stores:** stores to index 5 in cycles N and N+1 with `be=0001` (0x…01) then `be=1000` (0x02…). Cycle N+2 reads 32'h0200_0001 over a zeroed word.
- **MMIO:**
  - After reset, the counter reads 0, then 7 seven cycles later.
  - Store 32'h0000_00A5 to offset 4 gives `mmio_out` = 32'hA5 on the next cycle.
- **Errors:**
  - Fetch with `pcF` = 0xBFC0_0002 sets `addr_err`, `err_addr` = 0xBFC0_0002 and `instrF` = 0.
  - A later unmapped store leaves `err_addr` unchanged.
  - A store to status clears the flag.
- **Reset mid-store:** `rst`=0 in the cycle after a store. The array word is unchanged and all outputs return to their reset values.

Source files
------------

// File: rtl/cpu_mem_responder_pkg.sv
// Shared types and constants for the CPU memory responder.
// CPU_MEM_MMIO_EN enables the MMIO window; without it the window decodes as unmapped.
package cpu_mem_responder_pkg;

  localparam logic [31:0] PHYS_MASK = 32'h1FFF_FFFF;

  localparam logic [1:0] MMIO_CYCLE  = 2'd0;
  localparam logic [1:0] MMIO_OUT    = 2'd1;
  localparam logic [1:0] MMIO_STATUS = 2'd2;

`ifdef CPU_MEM_MMIO_EN
  localparam bit MMIO_EN = 1'b1;
`else
  localparam bit MMIO_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    REG_RAM,
    REG_MMIO,
    REG_UNMAPPED
  } region_e;

  // idx is sized for the largest possible array so the struct is not parameterized
  typedef struct packed {
    logic        valid;
    logic [29:0] idx;
    logic [3:0]  be;
    logic [31:0] data;
  } sb_entry_t;

endpackage

// File: rtl/mem_addr_decode.sv
// Combinational address classifier: virtual address to region, word index and MMIO offset.
// With ALIGN_CHECK set, a non-word-aligned address classifies as unmapped.
module mem_addr_decode
  import cpu_mem_responder_pkg::*;
#(
  parameter int          DEPTH_LOG2  = 10,
  parameter logic [31:0] MMIO_BASE   = 32'h1FAF_0000,
  parameter bit          ALIGN_CHECK = 1'b0
) (
  input  logic [31:0]           i_va,
  output region_e               o_region,
  output logic [DEPTH_LOG2-1:0] o_index,
  output logic [1:0]            o_offset
);

  logic [31:0] w_pa;
  logic        w_ramHit;
  logic        w_mmioHit;
  logic        w_misaligned;

  assign w_pa         = i_va & PHYS_MASK;
  assign w_ramHit     = (w_pa[31:DEPTH_LOG2+2] == '0);
  assign w_mmioHit    = MMIO_EN && (w_pa[31:4] == MMIO_BASE[31:4]);
  assign w_misaligned = ALIGN_CHECK && (w_pa[1:0] != 2'b00);

  always_comb begin
    o_region = REG_UNMAPPED;
    if (w_misaligned) begin
      o_region = REG_UNMAPPED;
    end else if (w_ramHit) begin
      o_region = REG_RAM;
    end else if (w_mmioHit) begin
      o_region = REG_MMIO;
    end
  end

  assign o_index  = w_pa[DEPTH_LOG2+1:2];
  assign o_offset = w_pa[3:2];

endmodule

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the pipelined core: word RAM with a one-entry store buffer,
// byte-lane forwarding and, when CPU_MEM_MMIO_EN is defined, a cycle counter/output/status window.
module cpu_mem_responder
  import cpu_mem_responder_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] MMIO_BASE  = 32'h1FAF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pcF,
  output logic [31:0] instrF,
  input  logic [31:0] aluoutM,
  input  logic [3:0]  memwriteM,
  input  logic [31:0] writedataM,
  output logic [31:0] readdataM,
  output logic [31:0] mmio_out,
  output logic        addr_err,
  output logic [31:0] err_addr
);

  logic [31:0] r_mem [2**DEPTH_LOG2];
  sb_entry_t   r_sb;
  logic        r_addrErr;
  logic [31:0] r_errAddr;

  region_e               w_fRegion, w_dRegion;
  logic [DEPTH_LOG2-1:0] w_fIdx, w_dIdx;
  logic [1:0]            w_fOffset, w_dOffset;
  logic [31:0]           w_fRaw, w_dRaw, w_fFwd, w_dFwd;
  logic [31:0]           w_cycle, w_mmioOut, w_errVa;
  logic                  w_storeEn, w_ramStore, w_mmioStore, w_statusClr;
  logic                  w_dErr, w_fErr, w_errEvent;

  // The fetch port treats misaligned PCs as unmapped so they read as NOP and flag an error.
  mem_addr_decode #(.DEPTH_LOG2(DEPTH_LOG2), .MMIO_BASE(MMIO_BASE), .ALIGN_CHECK(1'b1)) u_fetchDecode (
    .i_va     (pcF),
    .o_region (w_fRegion),
    .o_index  (w_fIdx),
    .o_offset (w_fOffset)
  );

  mem_addr_decode #(.DEPTH_LOG2(DEPTH_LOG2), .MMIO_BASE(MMIO_BASE), .ALIGN_CHECK(1'b0)) u_dataDecode (
    .i_va     (aluoutM),
    .o_region (w_dRegion),
    .o_index  (w_dIdx),
    .o_offset (w_dOffset)
  );

  function automatic logic [31:0] forwardLanes(input logic [31:0] word, input logic hit,
                                               input logic [3:0] be, input logic [31:0] data);
    logic [31:0] merged;
    merged = word;
    for (int i = 0; i < 4; i++) begin
      if (hit && be[i]) merged[8*i +: 8] = data[8*i +: 8];
    end
    return merged;
  endfunction

  assign w_fRaw = r_mem[w_fIdx];
  assign w_dRaw = r_mem[w_dIdx];
  assign w_fFwd = forwardLanes(w_fRaw, r_sb.valid && (r_sb.idx == 30'(w_fIdx)), r_sb.be, r_sb.data);
  assign w_dFwd = forwardLanes(w_dRaw, r_sb.valid && (r_sb.idx == 30'(w_dIdx)), r_sb.be, r_sb.data);

  assign w_storeEn   = |memwriteM;
  assign w_ramStore  = w_storeEn && (w_dRegion == REG_RAM);
  assign w_mmioStore = w_storeEn && (w_dRegion == REG_MMIO);
  assign w_statusClr = w_mmioStore && (w_dOffset == MMIO_STATUS);
  assign w_dErr      = w_storeEn && (w_dRegion == REG_UNMAPPED);
  assign w_fErr      = (w_fRegion == REG_UNMAPPED);
  assign w_errEvent  = w_dErr || w_fErr;
  assign w_errVa     = w_dErr ? aluoutM : pcF;

  assign instrF = (w_fRegion == REG_RAM) ? w_fFwd : 32'h0;

  always_comb begin
    readdataM = 32'h0;
    case (w_dRegion)
      REG_RAM: readdataM = w_dFwd;
      REG_MMIO: begin
        case (w_dOffset)
          MMIO_CYCLE:  readdataM = w_cycle;
          MMIO_OUT:    readdataM = w_mmioOut;
          MMIO_STATUS: readdataM = {31'b0, r_addrErr};
          default:     readdataM = 32'h0;
        endcase
      end
      default: readdataM = 32'h0;
    endcase
  end

  // A new store always replaces the entry; the old entry commits on the same edge below.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sb <= '0;
    end else begin
      r_sb <= '{valid: w_ramStore, idx: 30'(w_dIdx), be: memwriteM, data: writedataM};
    end
  end

  always_ff @(posedge clk) begin
    if (rst && r_sb.valid) begin
      for (int i = 0; i < 4; i++) begin
        if (r_sb.be[i]) r_mem[r_sb.idx[DEPTH_LOG2-1:0]][8*i +: 8] <= r_sb.data[8*i +: 8];
      end
    end
  end

`ifdef CPU_MEM_MMIO_EN
  logic [31:0] r_cycle;
  logic [31:0] r_mmioOut;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cycle   <= 32'h0;
      r_mmioOut <= 32'h0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      if (w_mmioStore && (w_dOffset == MMIO_OUT)) begin
        for (int i = 0; i < 4; i++) begin
          if (memwriteM[i]) r_mmioOut[8*i +: 8] <= writedataM[8*i +: 8];
        end
      end
    end
  end

  assign w_cycle   = r_cycle;
  assign w_mmioOut = r_mmioOut;
`else
  assign w_cycle   = 32'h0;
  assign w_mmioOut = 32'h0;
`endif

  // A new error outranks a same-cycle status clear and then also recaptures the address.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_addrErr <= 1'b0;
      r_errAddr <= 32'h0;
    end else if (w_errEvent) begin
      r_addrErr <= 1'b1;
      if (!r_addrErr || w_statusClr) r_errAddr <= w_errVa;
    end else if (w_statusClr) begin
      r_addrErr <= 1'b0;
      r_errAddr <= 32'h0;
    end
  end

  assign mmio_out = w_mmioOut;
  assign addr_err = r_addrErr;
  assign err_addr = r_errAddr;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed self-checking bench for cpu_mem_responder; MMIO checks follow CPU_MEM_MMIO_EN.
module tb_cpu_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pcF;
  logic [31:0] instrF;
  logic [31:0] aluoutM;
  logic [3:0]  memwriteM;
  logic [31:0] writedataM;
  logic [31:0] readdataM;
  logic [31:0] mmio_out;
  logic        addr_err;
  logic [31:0] err_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_mem_responder #(.DEPTH_LOG2(10), .MMIO_BASE(32'h1FAF_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .pcF        (pcF),
    .instrF     (instrF),
    .aluoutM    (aluoutM),
    .memwriteM  (memwriteM),
    .writedataM (writedataM),
    .readdataM  (readdataM),
    .mmio_out   (mmio_out),
    .addr_err   (addr_err),
    .err_addr   (err_addr)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%08h expected=%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] addr,
                               input logic [3:0] we, input logic [31:0] wd);
    pcF        = pc;
    aluoutM    = addr;
    memwriteM  = we;
    writedataM = wd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b0;
    applyStimulus(32'h0, 32'h0, 4'b0000, 32'h0);
    tick();
    tick();
    rst = 1'b1;
    applyStimulus(32'h0, 32'hBFAF_0000, 4'b0000, 32'h0);
    checkOutput("reset_addr_err", {31'b0, addr_err}, 32'h0);
    checkOutput("reset_err_addr", err_addr, 32'h0);
    checkOutput("reset_mmio_out", mmio_out, 32'h0);
    checkOutput("counter_first", readdataM, 32'h0);
    for (int i = 0; i < 7; i++) tick();
`ifdef CPU_MEM_MMIO_EN
    checkOutput("counter_seven", readdataM, 32'h7);
`else
    checkOutput("mmio_unmapped_read", readdataM, 32'h0);
`endif

    // store then load: forwarded next cycle, from the array later
    applyStimulus(32'h0, 32'h8000_0010, 4'b1111, 32'hDEAD_BEEF);
    tick();
    applyStimulus(32'h8000_0010, 32'h8000_0010, 4'b0000, 32'h0);
    checkOutput("fwd_load", readdataM, 32'hDEAD_BEEF);
    checkOutput("fwd_fetch", instrF, 32'hDEAD_BEEF);
    tick();
    tick();
    checkOutput("array_load", readdataM, 32'hDEAD_BEEF);

    // byte-lane merge
    applyStimulus(32'h0, 32'h0000_0020, 4'b1111, 32'h1122_3344);
    tick();
    applyStimulus(32'h0, 32'h0000_0020, 4'b0010, 32'h0000_AA00);
    tick();
    applyStimulus(32'h0, 32'h0000_0020, 4'b0000, 32'h0);
    checkOutput("lane_merge_fwd", readdataM, 32'h1122_AA44);
    tick();
    tick();
    checkOutput("lane_merge_array", readdataM, 32'h1122_AA44);

    // back-to-back stores to index 5 over a zeroed word
    applyStimulus(32'h0, 32'h0000_0014, 4'b1111, 32'h0);
    tick();
    applyStimulus(32'h0, 32'h0000_0014, 4'b0001, 32'h0000_0001);
    tick();
    applyStimulus(32'h0, 32'h0000_0014, 4'b1000, 32'h0200_0000);
    tick();
    applyStimulus(32'h0, 32'h0000_0014, 4'b0000, 32'h0);
    checkOutput("b2b_fwd", readdataM, 32'h0200_0001);
    tick();
    tick();
    checkOutput("b2b_array", readdataM, 32'h0200_0001);

    // fetch and store to the same word in one cycle: fetch sees the old value
    applyStimulus(32'h0000_0014, 32'h0000_0014, 4'b1111, 32'hCAFE_F00D);
    checkOutput("fetch_pre_store", instrF, 32'h0200_0001);
    tick();
    applyStimulus(32'h0000_0014, 32'h0, 4'b0000, 32'h0);
    checkOutput("fetch_post_store", instrF, 32'hCAFE_F00D);

    // error capture
    checkOutput("no_err_yet", {31'b0, addr_err}, 32'h0);
    applyStimulus(32'hBFC0_0002, 32'h0, 4'b0000, 32'h0);
    checkOutput("bad_fetch_nop", instrF, 32'h0);
    tick();
    checkOutput("bad_fetch_flag", {31'b0, addr_err}, 32'h1);
    checkOutput("bad_fetch_addr", err_addr, 32'hBFC0_0002);
    applyStimulus(32'h0, 32'h0000_2000, 4'b1111, 32'h5555_5555);
    tick();
    applyStimulus(32'h0, 32'h0000_2000, 4'b0000, 32'h0);
    checkOutput("unmapped_load", readdataM, 32'h0);
    checkOutput("sticky_flag", {31'b0, addr_err}, 32'h1);
    checkOutput("sticky_addr", err_addr, 32'hBFC0_0002);

    // MMIO output and status
    applyStimulus(32'h0, 32'hBFAF_0004, 4'b1111, 32'h0000_00A5);
    tick();
`ifdef CPU_MEM_MMIO_EN
    applyStimulus(32'h0, 32'hBFAF_0004, 4'b0000, 32'h0);
    checkOutput("mmio_out_write", mmio_out, 32'h0000_00A5);
    checkOutput("mmio_out_read", readdataM, 32'h0000_00A5);
    applyStimulus(32'h0, 32'hBFAF_0008, 4'b0000, 32'h0);
    checkOutput("status_read", readdataM, 32'h1);
    applyStimulus(32'h0, 32'hBFAF_0008, 4'b1111, 32'h0);
    tick();
    checkOutput("status_clear_flag", {31'b0, addr_err}, 32'h0);
    checkOutput("status_clear_addr", err_addr, 32'h0);
    applyStimulus(32'h0, 32'hBFAF_0008, 4'b1111, 32'h0);
    tick();
    applyStimulus(32'h0000_0006, 32'hBFAF_0008, 4'b1111, 32'h0);
    tick();
    checkOutput("clear_vs_set_flag", {31'b0, addr_err}, 32'h1);
    checkOutput("clear_vs_set_addr", err_addr, 32'h0000_0006);
`else
    applyStimulus(32'h0, 32'hBFAF_0008, 4'b0000, 32'h0);
    checkOutput("mmio_out_tied", mmio_out, 32'h0);
    checkOutput("status_unmapped", readdataM, 32'h0);
    applyStimulus(32'h0, 32'hBFAF_0008, 4'b1111, 32'h0);
    tick();
    checkOutput("no_clear_flag", {31'b0, addr_err}, 32'h1);
    checkOutput("no_clear_addr", err_addr, 32'hBFC0_0002);
`endif

    // reset one cycle after a store discards it
    applyStimulus(32'h0, 32'h0000_0010, 4'b1111, 32'h1234_5678);
    tick();
    rst = 1'b0;
    applyStimulus(32'h0, 32'h0000_0010, 4'b0000, 32'h0);
    tick();
    rst = 1'b1;
    applyStimulus(32'h0, 32'h0000_0010, 4'b0000, 32'h0);
    checkOutput("rst_store_dropped", readdataM, 32'hDEAD_BEEF);
    checkOutput("rst2_addr_err", {31'b0, addr_err}, 32'h0);
    checkOutput("rst2_err_addr", err_addr, 32'h0);
    checkOutput("rst2_mmio_out", mmio_out, 32'h0);
    applyStimulus(32'h0, 32'hBFAF_0000, 4'b0000, 32'h0);
    checkOutput("rst2_counter", readdataM, 32'h0);

    // data error outranks a simultaneous fetch error for the captured address
    applyStimulus(32'h0000_0003, 32'h0000_2000, 4'b0100, 32'h0);
    tick();
    applyStimulus(32'h0, 32'h0, 4'b0000, 32'h0);
    checkOutput("prio_flag", {31'b0, addr_err}, 32'h1);
    checkOutput("prio_addr", err_addr, 32'h0000_2000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
